i2c_responder: RTL and testbench

Synthesizable I2C target (slave) responder that sits on the far side of the I2C bus from the Wishbone-to-I2C master bridge. It watches the wired-AND SCL/SDA lines and drives only the `resp_sda_o` pull-down. It decodes START/STOP, matches a 7-bit address, and ACKs. It serves writes into, and reads from, a 16×8 internal register file addressed by a byte pointer. The integration testbench uses it as the master's bus partner; it is also reusable as an on-chip target.

---
 rtl/i2c_responder.sv | 144 ++++++++++++++
 tb/tb_i2c_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_responder.sv
// i2c_responder: I2C target with 7-bit address match and a 2^MEM_AW x 8 register file behind a byte pointer.
// Define I2C_RESP_AUTOINC_EN to advance the pointer after every data byte.
module i2c_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int MEM_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2c_scl_i,
    input  logic              i2c_sda_i,
    output logic              resp_sda_o,
    output logic              busy,
    output logic              wr_stb,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);
`ifdef I2C_RESP_AUTOINC_EN
    localparam logic [MEM_AW-1:0] P_INC = 1;
`else
    localparam logic [MEM_AW-1:0] P_INC = 0;
`endif
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WR, S_RD, S_WAIT} state_t;
    state_t            r_state;
    logic              r_scl_s1, r_scl_s2, r_scl_p, r_sda_s1, r_sda_s2, r_sda_p;
    logic [6:0]        r_shift;
    logic [7:0]        r_tx;
    logic [2:0]        r_bit;
    logic              r_done, r_ph9, r_rw, r_first;
    logic [MEM_AW-1:0] r_ptr;
    logic              r_sda, r_busy, r_wr_stb;
    logic [MEM_AW-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_mem [2**MEM_AW];
    logic              w_rise, w_fall, w_start, w_stop;
    logic [7:0]        w_byte, w_rd_byte;
    assign w_rise     = r_scl_s2 & ~r_scl_p;
    assign w_fall     = ~r_scl_s2 & r_scl_p;
    assign w_start    = r_scl_s2 & r_scl_p & r_sda_p & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_p & ~r_sda_p & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_rd_byte  = r_mem[r_ptr];
    assign resp_sda_o = r_sda;
    assign busy       = r_busy;
    assign wr_stb     = r_wr_stb;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign dbg_data   = r_mem[dbg_addr];
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_p, r_sda_s1, r_sda_s2, r_sda_p} <= '1;
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_tx      <= '0;
            r_bit     <= '0;
            r_done    <= 1'b0;
            r_ph9     <= 1'b0;
            r_rw      <= 1'b0;
            r_first   <= 1'b0;
            r_ptr     <= '0;
            r_sda     <= 1'b1;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < 2**MEM_AW; i++) r_mem[i] <= '0;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_p} <= {i2c_scl_i, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_p} <= {i2c_sda_i, r_sda_s1, r_sda_s2};
            r_wr_stb <= 1'b0;
            if (w_start) begin
                r_state <= S_ADDR;
                r_bit   <= '0;
                r_done  <= 1'b0;
                r_ph9   <= 1'b0;
                r_sda   <= 1'b1;
                r_busy  <= 1'b1;
            end else if (w_stop) begin
                r_state <= S_IDLE;
                r_done  <= 1'b0;
                r_ph9   <= 1'b0;
                r_sda   <= 1'b1;
                r_busy  <= 1'b0;
            end else if (r_state inside {S_ADDR, S_WR, S_RD}) begin
                if (w_rise) begin
                    if (r_ph9) begin
                        // master NACK on a read byte ends the transfer
                        if (r_state == S_RD && r_sda_s2) begin
                            r_state <= S_WAIT;
                            r_ph9   <= 1'b0;
                        end
                    end else if (!r_done) begin
                        r_shift <= w_byte[6:0];
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_done <= 1'b1;
                            if (r_state == S_ADDR) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_first <= ~w_byte[0];
                                end else begin
                                    r_state <= S_WAIT;
                                    r_done  <= 1'b0;
                                end
                            end else if (r_state == S_WR) begin
                                if (r_first) begin
                                    r_ptr   <= w_byte[MEM_AW-1:0];
                                    r_first <= 1'b0;
                                end else begin
                                    r_mem[r_ptr] <= w_byte;
                                    r_wr_stb     <= 1'b1;
                                    r_wr_addr    <= r_ptr;
                                    r_wr_data    <= w_byte;
                                    r_ptr        <= r_ptr + P_INC;
                                end
                            end else begin
                                r_ptr <= r_ptr + P_INC;
                            end
                        end
                    end
                end else if (w_fall) begin
                    if (r_done) begin
                        r_done <= 1'b0;
                        r_ph9  <= 1'b1;
                        r_sda  <= (r_state == S_RD);
                    end else if (r_ph9) begin
                        r_ph9 <= 1'b0;
                        if (r_state == S_RD || (r_state == S_ADDR && r_rw)) begin
                            r_state <= S_RD;
                            r_tx    <= w_rd_byte;
                            r_sda   <= w_rd_byte[7];
                        end else begin
                            r_state <= S_WR;
                            r_sda   <= 1'b1;
                        end
                    end else if (r_state == S_RD) begin
                        r_sda <= r_tx[3'd7 - r_bit];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_responder.sv
// tb_i2c_responder: bit-banged I2C master with a transaction-level register-file model.
module tb_i2c_responder;
    localparam logic [6:0] DEV = 7'h50;
`ifdef I2C_RESP_AUTOINC_EN
    localparam int INC = 1;
`else
    localparam int INC = 0;
`endif
    logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_sda = 1'b1;
    logic       sda_bus, resp_sda_o, busy, wr_stb;
    logic [3:0] wr_addr, dbg_addr = '0;
    logic [7:0] wr_data, dbg_data;
    int         n_chk = 0, n_err = 0, n_low = 0;
    logic [7:0] m_mem [16];
    logic [3:0] m_ptr = '0;
    logic [11:0] q_exp[$], q_obs[$];
    logic [7:0] bq[$];

    assign sda_bus = m_sda & resp_sda_o;
    always #5 clk = ~clk;

    i2c_responder dut (
        .clk(clk), .rst(rst), .i2c_scl_i(scl), .i2c_sda_i(sda_bus),
        .resp_sda_o(resp_sda_o), .busy(busy), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always @(posedge clk) begin
        if (wr_stb) q_obs.push_back({wr_addr, wr_data});
        if (!resp_sda_o) n_low <= n_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic r);
        m_sda = b;
        wclk(4);
        scl = 1'b1;
        wclk(8);
        r = sda_bus;
        scl = 1'b0;
        wclk(4);
    endtask

    // usable both from idle and as a repeated start with SCL low
    task automatic start_c();
        m_sda = 1'b1;
        wclk(4);
        scl = 1'b1;
        wclk(6);
        m_sda = 1'b0;
        wclk(6);
        scl = 1'b0;
        wclk(4);
    endtask

    task automatic stop_c(input logic chk_busy);
        m_sda = 1'b0;
        wclk(4);
        scl = 1'b1;
        wclk(6);
        m_sda = 1'b1;
        wclk(2);
        if (chk_busy) check("busy_hold", busy, 1);
        wclk(4);
        check("busy_stop", busy, 0);
        wclk(4);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(b[i], r);
        send_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, r);
            d[i] = r;
        end
        send_bit(nack, r);
    endtask

    task automatic scan();
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            check($sformatf("mem%0d", i), dbg_data, m_mem[i]);
        end
    endtask

    task automatic cmp_stb();
        check("stb_cnt", q_obs.size(), q_exp.size());
        for (int i = 0; i < q_obs.size() && i < q_exp.size(); i++) check("stb", q_obs[i], q_exp[i]);
        q_obs.delete();
        q_exp.delete();
    endtask

    // bq[0] is the pointer byte, the rest are data bytes
    task automatic t_write(input logic [6:0] a);
        logic ack;
        logic match;
        int   l0;
        match = (a == DEV);
        l0 = n_low;
        start_c();
        wr_byte({a, 1'b0}, ack);
        check("addr_ack", ack, match);
        for (int k = 0; k < bq.size(); k++) begin
            wr_byte(bq[k], ack);
            check("data_ack", ack, match);
            if (match && k == 0) m_ptr = bq[0][3:0];
            else if (match) begin
                m_mem[m_ptr] = bq[k];
                q_exp.push_back({m_ptr, bq[k]});
                m_ptr = m_ptr + 4'(INC);
            end
        end
        stop_c(1'b1);
        if (!match) check("nack_low", n_low - l0, 0);
        cmp_stb();
        scan();
    endtask

    task automatic t_read(input logic set_ptr, input logic [7:0] p, input int n);
        logic ack;
        logic [7:0] d;
        start_c();
        if (set_ptr) begin
            wr_byte({DEV, 1'b0}, ack);
            check("rw_addr_ack", ack, 1);
            wr_byte(p, ack);
            check("rw_ptr_ack", ack, 1);
            m_ptr = p[3:0];
            start_c();
        end
        wr_byte({DEV, 1'b1}, ack);
        check("rd_addr_ack", ack, 1);
        for (int k = 0; k < n; k++) begin
            rd_byte(k == n - 1, d);
            check("rd_data", d, m_mem[m_ptr]);
            m_ptr = m_ptr + 4'(INC);
        end
        check("rd_release", resp_sda_o, 1);
        stop_c(1'b1);
        cmp_stb();
    endtask

    task automatic t_partial(input logic [7:0] p);
        logic ack;
        logic r;
        start_c();
        wr_byte({DEV, 1'b0}, ack);
        wr_byte(p, ack);
        check("part_ptr_ack", ack, 1);
        m_ptr = p[3:0];
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), r);
        stop_c(1'b1);
        cmp_stb();
        scan();
    endtask

    initial begin
        logic ack;
        int   t;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        wclk(3);
        rst = 1'b0;
        check("rst_sda", resp_sda_o, 1);
        check("rst_busy", busy, 0);
        check("rst_stb", wr_stb, 0);
        check("rst_waddr", wr_addr, 0);
        check("rst_wdata", wr_data, 0);
        scan();
        wclk(10);

        bq = {};
        bq.push_back(8'h03); bq.push_back(8'hA5); bq.push_back(8'h5A);
        t_write(DEV);
        t_read(1'b1, 8'h03, 2);
        bq = {};
        bq.push_back(8'h33);
        t_write(7'h51);
        bq = {};
        bq.push_back(8'h0F); bq.push_back(8'h11); bq.push_back(8'h22);
        t_write(DEV);
        t_partial(8'h07);

        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    bq = {};
                    bq.push_back(8'($urandom));
                    for (int k = $urandom_range(0, 4); k > 0; k--) bq.push_back(8'($urandom));
                    t_write(DEV);
                end
                1: t_read(1'b1, 8'($urandom), $urandom_range(1, 4));
                2: t_read(1'b0, 8'h00, $urandom_range(1, 3));
                3: begin
                    bq = {};
                    bq.push_back(8'($urandom));
                    bq.push_back(8'($urandom));
                    t_write(DEV ^ 7'($urandom_range(1, 127)));
                end
                default: t_partial(8'($urandom));
            endcase
        end

        bq = {};
        bq.push_back(8'h05); bq.push_back(8'h3C);
        t_write(DEV);
        start_c();
        wr_byte({DEV, 1'b0}, ack);
        wr_byte(8'h05, ack);
        start_c();
        wr_byte({DEV, 1'b1}, ack);
        check("rr_addr_ack", ack, 1);
        t = 0;
        while (resp_sda_o && t < 40) begin
            wclk(1);
            t++;
        end
        check("rd_bit0_driven", resp_sda_o, 0);
        rst = 1'b1;
        wclk(1);
        rst = 1'b0;
        check("midrst_sda", resp_sda_o, 1);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_ptr = '0;
        scan();
        stop_c(1'b0);
        q_obs.delete();
        q_exp.delete();
        t_read(1'b0, 8'h00, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule
